// File: rtl/onehot_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : onehot_alu_driver
// Purpose  : Sequential initiator for the one-hot ALU datapath. Takes binary
//            requests (4-bit operands, 3-bit opcode) on a valid/ready port,
//            drives one-hot operands to the ALU, holds them for SETTLE_CYCLES
//            cycles, samples the one-hot result/overflow, checks it is
//            exactly one-hot, decodes it and returns it on a valid/ready
//            response port.
// Ports    : clk, rst                       - clock, synchronous active-high reset
//            req_valid/req_ready            - request handshake
//            req_a, req_b, req_opc          - binary request fields
//            alu_inp1, alu_inp2, alu_opc    - one-hot operands and opcode to ALU
//            alu_out, alu_overflow          - one-hot result and overflow from ALU
//            rsp_valid/rsp_ready            - response handshake
//            rsp_result, rsp_overflow,
//            rsp_error                      - decoded result and status
//            err_count                      - saturating count of bad results
// Revision : 1.0 - initial release
// ============================================================================
module onehot_alu_driver #(
    parameter int SETTLE_CYCLES = 1     // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_a,
    input  logic [3:0]  req_b,
    input  logic [2:0]  req_opc,
    output logic [15:0] alu_inp1,
    output logic [15:0] alu_inp2,
    output logic [2:0]  alu_opc,
    input  logic [15:0] alu_out,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_error,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] C_CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [15:0] r_inp1;
    logic [15:0] r_inp2;
    logic [2:0]  r_opc;
    logic [3:0]  r_result;
    logic        r_overflow;
    logic        r_error;
    logic [7:0]  r_err_count;

    logic        w_onehot;
    logic [3:0]  w_idx;

    // x & (x-1) clears the lowest set bit: zero only when at most one bit is set.
    assign w_onehot = (alu_out != 16'd0) && ((alu_out & (alu_out - 16'd1)) == 16'd0);

    // Index of a set bit; only meaningful when w_onehot is true, so no
    // priority resolution is needed for multi-bit values.
    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (alu_out[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_inp1      <= 16'h0001;
            r_inp2      <= 16'h0001;
            r_opc       <= 3'd0;
            r_result    <= 4'd0;
            r_overflow  <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_inp1      <= 16'h0001 << req_a;
                        r_inp2      <= 16'h0001 << req_b;
                        r_opc       <= req_opc;
                        r_cnt       <= C_CNT_INIT;
                        r_req_ready <= 1'b0;
                        r_state     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_result   <= w_onehot ? w_idx : 4'd0;
                        r_error    <= ~w_onehot;
                        r_overflow <= alu_overflow;
                        if (!w_onehot && (r_err_count != 8'hFF)) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign alu_inp1     = r_inp1;
    assign alu_inp2     = r_inp2;
    assign alu_opc      = r_opc;
    assign rsp_result   = r_result;
    assign rsp_overflow = r_overflow;
    assign rsp_error    = r_error;
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_onehot_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_alu_driver
// Purpose  : Directed self-checking bench. Two instances share all inputs:
//            u_dut1 (SETTLE_CYCLES=1) and u_dut3 (SETTLE_CYCLES=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_alu_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_a = 4'd0;
    logic [3:0]  req_b = 4'd0;
    logic [2:0]  req_opc = 3'd0;
    logic [15:0] alu_out = 16'h0001;
    logic        alu_overflow = 1'b0;
    logic        rsp_ready = 1'b0;

    logic        req_ready_1, rsp_valid_1, rsp_overflow_1, rsp_error_1;
    logic [15:0] alu_inp1_1, alu_inp2_1;
    logic [2:0]  alu_opc_1;
    logic [3:0]  rsp_result_1;
    logic [7:0]  err_count_1;

    logic        req_ready_3, rsp_valid_3, rsp_overflow_3, rsp_error_3;
    logic [15:0] alu_inp1_3, alu_inp2_3;
    logic [2:0]  alu_opc_3;
    logic [3:0]  rsp_result_3;
    logic [7:0]  err_count_3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    onehot_alu_driver #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_1),
        .req_a(req_a), .req_b(req_b), .req_opc(req_opc),
        .alu_inp1(alu_inp1_1), .alu_inp2(alu_inp2_1), .alu_opc(alu_opc_1),
        .alu_out(alu_out), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result_1), .rsp_overflow(rsp_overflow_1),
        .rsp_error(rsp_error_1), .err_count(err_count_1)
    );

    onehot_alu_driver #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_3),
        .req_a(req_a), .req_b(req_b), .req_opc(req_opc),
        .alu_inp1(alu_inp1_3), .alu_inp2(alu_inp2_3), .alu_opc(alu_opc_3),
        .alu_out(alu_out), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result_3), .rsp_overflow(rsp_overflow_3),
        .rsp_error(rsp_error_3), .err_count(err_count_3)
    );

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // One full transaction on u_dut1 (starting in IDLE), response acknowledged.
    task automatic txn1(input logic [15:0] out, input logic ovf);
        req_a = 4'd1; req_b = 4'd2; req_opc = 3'd0; req_valid = 1'b1;
        rsp_ready = 1'b0; alu_out = out; alu_overflow = ovf;
        tick();
        req_valid = 1'b0;
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (req_ready_1 !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready_1); end
        n_tests++; if (rsp_valid_1 !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_1); end
        n_tests++; if (alu_inp1_1 !== 16'h0001) begin n_fail++; $display("FAIL reset_inp1 got=%h exp=0001", alu_inp1_1); end
        n_tests++; if (alu_inp2_1 !== 16'h0001) begin n_fail++; $display("FAIL reset_inp2 got=%h exp=0001", alu_inp2_1); end
        n_tests++; if (alu_opc_1 !== 3'd0) begin n_fail++; $display("FAIL reset_opc got=%0d exp=0", alu_opc_1); end
        n_tests++; if (err_count_1 !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got=%0d exp=0", err_count_1); end
        n_tests++; if ({rsp_result_1, rsp_overflow_1, rsp_error_1} !== 6'd0) begin n_fail++; $display("FAIL reset_rsp_fields got=%b exp=0", {rsp_result_1, rsp_overflow_1, rsp_error_1}); end
        n_tests++; if ({req_ready_3, rsp_valid_3, alu_inp1_3} !== {2'b10, 16'h0001}) begin n_fail++; $display("FAIL reset_dut3 got=%h exp=20001", {req_ready_3, rsp_valid_3, alu_inp1_3}); end
    endtask

    task automatic test_single_and_backpressure();
        do_reset();
        req_a = 4'd3; req_b = 4'd5; req_opc = 3'b010; req_valid = 1'b1;
        alu_out = 16'h0100; alu_overflow = 1'b1; rsp_ready = 1'b0;
        tick();   // accept edge
        req_valid = 1'b0;
        n_tests++; if (alu_inp1_1 !== 16'h0008) begin n_fail++; $display("FAIL single_inp1 got=%h exp=0008", alu_inp1_1); end
        n_tests++; if (alu_inp2_1 !== 16'h0020) begin n_fail++; $display("FAIL single_inp2 got=%h exp=0020", alu_inp2_1); end
        n_tests++; if (alu_opc_1 !== 3'b010) begin n_fail++; $display("FAIL single_opc got=%b exp=010", alu_opc_1); end
        n_tests++; if ({req_ready_1, rsp_valid_1} !== 2'b00) begin n_fail++; $display("FAIL single_drive_hs got=%b exp=00", {req_ready_1, rsp_valid_1}); end
        tick();   // sampling edge
        n_tests++; if (rsp_valid_1 !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid_1); end
        n_tests++; if ({rsp_result_1, rsp_overflow_1, rsp_error_1} !== {4'd8, 1'b1, 1'b0}) begin n_fail++; $display("FAIL single_rsp got=%b exp=%b", {rsp_result_1, rsp_overflow_1, rsp_error_1}, {4'd8, 1'b1, 1'b0}); end

        // Backpressure with a new request pending
        req_a = 4'd7; req_b = 4'd9; req_opc = 3'd5; req_valid = 1'b1;
        alu_out = 16'h0002; alu_overflow = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if ({rsp_valid_1, req_ready_1, rsp_result_1, rsp_overflow_1, rsp_error_1} !== {2'b10, 4'd8, 2'b10}) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%b exp=%b", i, {rsp_valid_1, req_ready_1, rsp_result_1, rsp_overflow_1, rsp_error_1}, {2'b10, 4'd8, 2'b10}); end
            n_tests++; if (alu_inp1_1 !== 16'h0008) begin n_fail++; $display("FAIL bp_inp1_hold cyc=%0d got=%h exp=0008", i, alu_inp1_1); end
        end
        rsp_ready = 1'b1;
        tick();   // handshake edge
        rsp_ready = 1'b0;
        n_tests++; if ({rsp_valid_1, req_ready_1} !== 2'b01) begin n_fail++; $display("FAIL bp_release got=%b exp=01", {rsp_valid_1, req_ready_1}); end
        n_tests++; if (rsp_result_1 !== 4'd8) begin n_fail++; $display("FAIL bp_result_kept got=%0d exp=8", rsp_result_1); end
        tick();   // accept of the pending request
        req_valid = 1'b0;
        n_tests++; if ({alu_inp1_1, alu_inp2_1, alu_opc_1} !== {16'h0080, 16'h0200, 3'd5}) begin n_fail++; $display("FAIL bp_second_accept got=%h exp=%h", {alu_inp1_1, alu_inp2_1, alu_opc_1}, {16'h0080, 16'h0200, 3'd5}); end
        tick();
        n_tests++; if ({rsp_valid_1, rsp_result_1, rsp_overflow_1} !== {1'b1, 4'd1, 1'b0}) begin n_fail++; $display("FAIL bp_second_rsp got=%b exp=%b", {rsp_valid_1, rsp_result_1, rsp_overflow_1}, {1'b1, 4'd1, 1'b0}); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_invalid();
        do_reset();
        txn1(16'h0000, 1'b1);
        n_tests++; if ({rsp_error_1, rsp_result_1, rsp_overflow_1} !== {1'b1, 4'd0, 1'b1}) begin n_fail++; $display("FAIL inv_zero got=%b exp=%b", {rsp_error_1, rsp_result_1, rsp_overflow_1}, {1'b1, 4'd0, 1'b1}); end
        n_tests++; if (err_count_1 !== 8'd1) begin n_fail++; $display("FAIL inv_zero_count got=%0d exp=1", err_count_1); end
        txn1(16'h0180, 1'b0);
        n_tests++; if ({rsp_error_1, rsp_result_1} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL inv_multi got=%b exp=%b", {rsp_error_1, rsp_result_1}, {1'b1, 4'd0}); end
        n_tests++; if (err_count_1 !== 8'd2) begin n_fail++; $display("FAIL inv_multi_count got=%0d exp=2", err_count_1); end
        txn1(16'h8000, 1'b0);
        n_tests++; if ({rsp_error_1, rsp_result_1, err_count_1} !== {1'b0, 4'd15, 8'd2}) begin n_fail++; $display("FAIL valid_top_bit got=%b exp=%b", {rsp_error_1, rsp_result_1, err_count_1}, {1'b0, 4'd15, 8'd2}); end
        for (int i = 0; i < 252; i++) txn1(16'h0000, 1'b0);
        n_tests++; if (err_count_1 !== 8'd254) begin n_fail++; $display("FAIL sat_254 got=%0d exp=254", err_count_1); end
        txn1(16'h0003, 1'b0);
        n_tests++; if (err_count_1 !== 8'd255) begin n_fail++; $display("FAIL sat_255 got=%0d exp=255", err_count_1); end
        for (int i = 0; i < 46; i++) txn1(16'hFFFF, 1'b0);
        n_tests++; if (err_count_1 !== 8'd255) begin n_fail++; $display("FAIL sat_hold got=%0d exp=255", err_count_1); end
    endtask

    task automatic test_settle3();
        do_reset();
        req_a = 4'd2; req_b = 4'd4; req_opc = 3'd1; req_valid = 1'b1;
        alu_overflow = 1'b0; alu_out = 16'h0000;
        tick();   // accept edge
        req_valid = 1'b0;
        alu_out = 16'h0001;
        n_tests++; if (rsp_valid_3 !== 1'b0) begin n_fail++; $display("FAIL s3_valid_c1 got=%b exp=0", rsp_valid_3); end
        tick();
        alu_out = 16'h0002;
        n_tests++; if (rsp_valid_3 !== 1'b0) begin n_fail++; $display("FAIL s3_valid_c2 got=%b exp=0", rsp_valid_3); end
        tick();
        alu_out = 16'h0004;
        n_tests++; if (rsp_valid_3 !== 1'b0) begin n_fail++; $display("FAIL s3_valid_c3 got=%b exp=0", rsp_valid_3); end
        n_tests++; if ({alu_inp1_3, alu_inp2_3} !== {16'h0004, 16'h0010}) begin n_fail++; $display("FAIL s3_inputs got=%h exp=%h", {alu_inp1_3, alu_inp2_3}, {16'h0004, 16'h0010}); end
        tick();   // third edge after accept: sampling edge
        alu_out = 16'h0008;
        n_tests++; if ({rsp_valid_3, rsp_result_3, rsp_error_3} !== {1'b1, 4'd2, 1'b0}) begin n_fail++; $display("FAIL s3_rsp got=%b exp=%b", {rsp_valid_3, rsp_result_3, rsp_error_3}, {1'b1, 4'd2, 1'b0}); end
        tick();
        n_tests++; if (rsp_result_3 !== 4'd2) begin n_fail++; $display("FAIL s3_rsp_stable got=%0d exp=2", rsp_result_3); end
    endtask

    task automatic test_reset_mid_drive();
        do_reset();
        txn1(16'h0000, 1'b0);   // leaves err_count at 1 before the aborted request
        req_a = 4'd6; req_b = 4'd6; req_opc = 3'd7; req_valid = 1'b1; alu_out = 16'h0040;
        tick();   // accept edge, DUT now in DRIVE
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if ({rsp_valid_1, req_ready_1} !== 2'b01) begin n_fail++; $display("FAIL mid_rst_hs cyc=%0d got=%b exp=01", i, {rsp_valid_1, req_ready_1}); end
            tick();
        end
        n_tests++; if ({alu_inp1_1, alu_inp2_1, alu_opc_1} !== {16'h0001, 16'h0001, 3'd0}) begin n_fail++; $display("FAIL mid_rst_alu got=%h exp=%h", {alu_inp1_1, alu_inp2_1, alu_opc_1}, {16'h0001, 16'h0001, 3'd0}); end
        n_tests++; if ({err_count_1, rsp_error_1} !== 9'd0) begin n_fail++; $display("FAIL mid_rst_err got=%h exp=0", {err_count_1, rsp_error_1}); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ta [4];
        logic [3:0] tb_ [4];
        logic [3:0] te [4];
        int n_acc, n_rsp, first, last;
        ta[0] = 4'd1;  tb_[0] = 4'd2; te[0] = 4'd3;
        ta[1] = 4'd6;  tb_[1] = 4'd3; te[1] = 4'd9;
        ta[2] = 4'd9;  tb_[2] = 4'd4; te[2] = 4'd13;
        ta[3] = 4'd15; tb_[3] = 4'd1; te[3] = 4'd0;
        n_acc = 0; n_rsp = 0; first = -1; last = -1;
        do_reset();
        rsp_ready = 1'b1;
        req_a = ta[0]; req_b = tb_[0]; req_opc = 3'd0; req_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && n_rsp < 4; cyc++) begin
            automatic logic acc = req_ready_3 && req_valid;
            if (rsp_valid_3 && rsp_ready) begin
                n_tests++; if (rsp_result_3 !== te[n_rsp]) begin n_fail++; $display("FAIL b2b_result idx=%0d got=%0d exp=%0d", n_rsp, rsp_result_3, te[n_rsp]); end
                n_rsp++;
                last = cyc;
            end
            tick();
            if (acc) begin
                if (n_acc == 0) first = cyc;
                alu_out = 16'h0001 << te[n_acc];
                n_acc++;
                if (n_acc < 4) begin
                    req_a = ta[n_acc]; req_b = tb_[n_acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        n_tests++; if (n_rsp !== 4) begin n_fail++; $display("FAIL b2b_timeout responses got=%0d exp=4", n_rsp); end
        n_tests++; if (last - first + 1 !== 20) begin n_fail++; $display("FAIL b2b_cycles got=%0d exp=20", last - first + 1); end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_and_backpressure();
        test_invalid();
        test_settle3();
        test_reset_mid_drive();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
